bp_cfg_seq_loader: RTL
======================

Name: bp_cfg_seq_loader

Overview:
- Runtime configuration sequencer that drives the cfg bus and loads a table of (addr, data) entries into every core of a multicore instance.
- Successor to the static per-configuration parameter set: generalised over core count, cfg bus widths and table depth.
- Adds a broadcast write mode, optional read-back verification and first-error capture.
- Sits between the host/boot controller and the per-core cfg bus endpoints.

Parameters:
- num_core_p, 4, number of target cores (1..2^cfg_core_width_p-1).
- cfg_core_width_p, 8, core-id field width.
- cfg_addr_width_p, 16, cfg address width.
- cfg_data_width_p, 32, cfg data width.
- num_entries_p, 4, table depth (>=1).
- broadcast_p, 0, 1 = one write pass to core id all-ones; 0 = a write pass per core.
- verify_p, 1, 1 = read back and compare every entry on every core after its writes.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  begin a load sequence; sampled only in IDLE or DONE.
- table_addr_i  in  num_entries_p*cfg_addr_width_p  entry addresses; entry 0 in the LSBs.
- table_data_i  in  num_entries_p*cfg_data_width_p  entry data; entry 0 in the LSBs.
- cfg_v_o  out  1  request valid.
- cfg_w_v_o  out  1  1 = write, 0 = read.
- cfg_core_o  out  cfg_core_width_p  target core id.
- cfg_addr_o  out  cfg_addr_width_p  target address.
- cfg_data_o  out  cfg_data_width_p  write data; 0 on reads.
- cfg_ready_i  in  1  request accepted when cfg_v_o & cfg_ready_i.
- cfg_rdata_v_i  in  1  read response valid.
- cfg_rdata_i  in  cfg_data_width_p  read response data.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete; held.
- error_o  out  1  sticky verify mismatch.
- err_core_o  out  cfg_core_width_p  core of the first mismatch.
- err_entry_o  out  lg(num_entries_p)  entry of the first mismatch.

Behaviour:
- Reset (async assert, sync deassert):
  - State goes to IDLE.
  - All outputs 0, including the core and entry counters and the error capture.
- States: IDLE, WRITE, READ, WAIT_RDATA, DONE.
- IDLE/DONE, start_i=1:
  - Next cycle enters WRITE with core=0, entry=0.
  - Clears done_o, error_o, err_core_o and err_entry_o.
  - start_i in any other state is ignored.
- WRITE:
  - Drives cfg_v_o=1, cfg_w_v_o=1, addr/data of the current entry.
  - cfg_core_o = all-ones if broadcast_p, else the current core.
  - On handshake: entry increments. After the last entry:
    - broadcast_p=1: go to READ (core 0, entry 0) if verify_p=1, else DONE.
    - broadcast_p=0 and verify_p=1: go to READ for the same core, entry 0.
    - broadcast_p=0 and verify_p=0: go to the next core's WRITE, or DONE after the last core.
- READ:
  - Drives cfg_v_o=1, cfg_w_v_o=0, cfg_data_o=0.
  - On handshake goes to WAIT_RDATA; cfg_v_o deasserts.
- WAIT_RDATA:
  - On cfg_rdata_v_i, compares cfg_rdata_i with the table data.
  - On mismatch with error_o=0: set error_o and capture the core and entry. Later mismatches do not overwrite the capture.
  - Advance entry:
    - Not the last entry: back to READ.
    - Last entry, broadcast_p=1: next core's READ, or DONE after the last core.
    - Last entry, broadcast_p=0: next core's WRITE, or DONE after the last core.
- Outputs are registered.
  - cfg_* holds stable while cfg_v_o=1 and cfg_ready_i=0.
  - The table inputs must stay stable while busy_o=1.
- Throughput: one request per cycle in WRITE with ready held high. Each verified read takes at least 2 cycles plus response latency.
- cfg_rdata_v_i outside WAIT_RDATA is ignored.
- A verify mismatch does not abort the sequence.
- busy_o = WRITE|READ|WAIT_RDATA. done_o=1 only in DONE.
- Entry and core counters wrap to 0 on advance. num_entries_p=1 is supported (lg width is 1).
- Reset mid-sequence aborts immediately. cfg_v_o drops asynchronously; there is no partial-state resume.

Test Plan:
- Defaults, broadcast_p=0, verify_p=1, ready=1, rdata echoes writes, 4 entries (0x10..0x13 → 0xA0..0xA3):
  - 16 writes and 16 reads occur, ordered core0 W0-3, R0-3, core1 ...
  - done_o=1, error_o=0.
- broadcast_p=1, verify_p=0: exactly 4 writes with cfg_core_o=0xFF, then done_o on the following cycle.
- Random cfg_ready_i stalls (30% low):
  - cfg_addr_o and cfg_data_o never change while cfg_v_o=1 and ready=0.
  - Total accepted requests equal the stall-free count.
- Corrupt the response for core 2 entry 1 (0xDEAD) and core 3 entry 0:
  - error_o=1, err_core_o=2, err_entry_o=1.
  - The sequence still completes.
- Deassert reset_n_i during core 1 WRITE:
  - All outputs 0 in the same cycle.
  - start_i afterward restarts at core 0 entry 0.
- start_i pulsed while busy: no effect. start_i pulsed in DONE: error cleared, a new sequence runs.

Source files
------------

// File: rtl/bp_cfg_seq_loader.sv
// Runtime configuration sequencer. Walks a table of (addr, data) entries and
// writes it to every core over the cfg bus, either as one broadcast pass to the
// all-ones core id or as one pass per core. It can optionally read back and
// compare every entry on every core, and it captures the first mismatch.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   start_i                 begin a load sequence (honoured in IDLE/DONE only)
//   table_addr_i/_data_i    packed entry table, entry 0 in the LSBs
//   cfg_v_o .. cfg_data_o   cfg request; accepted on cfg_v_o & cfg_ready_i
//   cfg_ready_i             request accept
//   cfg_rdata_v_i/_i        read response
//   busy_o, done_o          sequence status (done_o held in DONE)
//   error_o                 sticky verify mismatch
//   err_core_o/err_entry_o  location of the first mismatch
module bp_cfg_seq_loader #(
    parameter int unsigned num_core_p       = 4,
    parameter int unsigned cfg_core_width_p = 8,
    parameter int unsigned cfg_addr_width_p = 16,
    parameter int unsigned cfg_data_width_p = 32,
    parameter int unsigned num_entries_p    = 4,
    parameter bit          broadcast_p      = 1'b0,
    parameter bit          verify_p         = 1'b1,
    localparam int unsigned entry_width_lp  = (num_entries_p > 1) ? $clog2(num_entries_p) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      start_i,
    input  logic [num_entries_p*cfg_addr_width_p-1:0] table_addr_i,
    input  logic [num_entries_p*cfg_data_width_p-1:0] table_data_i,
    output logic                                      cfg_v_o,
    output logic                                      cfg_w_v_o,
    output logic [cfg_core_width_p-1:0]               cfg_core_o,
    output logic [cfg_addr_width_p-1:0]               cfg_addr_o,
    output logic [cfg_data_width_p-1:0]               cfg_data_o,
    input  logic                                      cfg_ready_i,
    input  logic                                      cfg_rdata_v_i,
    input  logic [cfg_data_width_p-1:0]               cfg_rdata_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      error_o,
    output logic [cfg_core_width_p-1:0]               err_core_o,
    output logic [entry_width_lp-1:0]                 err_entry_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWaitRdata,
        StDone
    } state_e;

    state_e                        state_q, state_d;
    logic [cfg_core_width_p-1:0]   core_q, core_d;
    logic [entry_width_lp-1:0]     entry_q, entry_d;
    logic                          error_q, error_d;
    logic [cfg_core_width_p-1:0]   err_core_q, err_core_d;
    logic [entry_width_lp-1:0]     err_entry_q, err_entry_d;

    logic [cfg_addr_width_p-1:0]   cur_addr;
    logic [cfg_data_width_p-1:0]   cur_data;
    logic                          last_entry;
    logic                          last_core;

    assign cur_addr   = table_addr_i[entry_q*cfg_addr_width_p +: cfg_addr_width_p];
    assign cur_data   = table_data_i[entry_q*cfg_data_width_p +: cfg_data_width_p];
    assign last_entry = (entry_q == entry_width_lp'(num_entries_p - 1));
    assign last_core  = (core_q == cfg_core_width_p'(num_core_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            core_q      <= '0;
            entry_q     <= '0;
            error_q     <= 1'b0;
            err_core_q  <= '0;
            err_entry_q <= '0;
        end else begin
            state_q     <= state_d;
            core_q      <= core_d;
            entry_q     <= entry_d;
            error_q     <= error_d;
            err_core_q  <= err_core_d;
            err_entry_q <= err_entry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        core_d      = core_q;
        entry_d     = entry_q;
        error_d     = error_q;
        err_core_d  = err_core_q;
        err_entry_d = err_entry_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d     = StWrite;
                    core_d      = '0;
                    entry_d     = '0;
                    error_d     = 1'b0;
                    err_core_d  = '0;
                    err_entry_d = '0;
                end
            end
            StWrite: begin
                if (cfg_ready_i) begin
                    if (last_entry) begin
                        entry_d = '0;
                        if (broadcast_p) begin
                            // The broadcast pass is verified core by core from core 0.
                            core_d  = '0;
                            state_d = verify_p ? StRead : StDone;
                        end else if (verify_p) begin
                            state_d = StRead;
                        end else if (last_core) begin
                            core_d  = '0;
                            state_d = StDone;
                        end else begin
                            core_d = core_q + 1'b1;
                        end
                    end else begin
                        entry_d = entry_q + 1'b1;
                    end
                end
            end
            StRead: begin
                if (cfg_ready_i) begin
                    state_d = StWaitRdata;
                end
            end
            StWaitRdata: begin
                if (cfg_rdata_v_i) begin
                    // Only the first mismatch is captured; the sequence carries on.
                    if ((cfg_rdata_i != cur_data) && !error_q) begin
                        error_d     = 1'b1;
                        err_core_d  = core_q;
                        err_entry_d = entry_q;
                    end
                    if (!last_entry) begin
                        entry_d = entry_q + 1'b1;
                        state_d = StRead;
                    end else begin
                        entry_d = '0;
                        if (last_core) begin
                            core_d  = '0;
                            state_d = StDone;
                        end else begin
                            core_d  = core_q + 1'b1;
                            state_d = broadcast_p ? StRead : StWrite;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only, so they drop as soon as reset asserts.
    always_comb begin
        cfg_v_o    = (state_q == StWrite) || (state_q == StRead);
        cfg_w_v_o  = (state_q == StWrite);
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        if (cfg_v_o) begin
            cfg_core_o = (cfg_w_v_o && broadcast_p) ? '1 : core_q;
            cfg_addr_o = cur_addr;
        end
        if (cfg_w_v_o) begin
            cfg_data_o = cur_data;
        end
    end

    assign busy_o      = (state_q == StWrite) || (state_q == StRead) || (state_q == StWaitRdata);
    assign done_o      = (state_q == StDone);
    assign error_o     = error_q;
    assign err_core_o  = err_core_q;
    assign err_entry_o = err_entry_q;

endmodule
